// File: rtl/apb_slv_regs.sv
// APB completer with an eight-entry 32-bit register bank and a fixed number of
// wait states. Undecoded addresses and writes to the transfer counter answer with PSLVERR.
module apb_slv_regs #(
   parameter logic [31:0] BASE_ADDR = 32'hDEADCAE0,
   parameter int unsigned WAIT_CYC  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        psel,
   input  logic        penable,
   input  logic [31:0] paddr,
   input  logic        pwrite,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr
);

   localparam logic [3:0] WaitInit = 4'(WAIT_CYC);
   localparam logic [2:0] CntIdx   = 3'd6;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic        hit_q, hit_d;
   logic [2:0]  idx_q, idx_d;
   logic        write_q, write_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] regs_q [8];
   logic [31:0] cnt_q, cnt_d;
   logic        cnt_inc;
   logic        reg_we;
   logic        capture;
   logic        sel_hit;
   logic [2:0]  sel_idx;
   logic        sel_write;
   logic        unused_addr;

   assign unused_addr = ^paddr[1:0];

   // In IDLE the response is decoded straight from the bus so a zero-wait
   // transfer can enter RESP on the setup edge; afterwards the latched copy is used.
   always_comb begin
      sel_hit   = hit_q;
      sel_idx   = idx_q;
      sel_write = write_q;
      if (state_q == StIdle) begin
         sel_hit   = (paddr[31:5] == BASE_ADDR[31:5]);
         sel_idx   = paddr[4:2];
         sel_write = pwrite;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      hit_d   = hit_q;
      idx_d   = idx_q;
      write_d = write_q;
      wdata_d = wdata_q;
      rdata_d = '0;
      err_d   = 1'b0;
      cnt_inc = 1'b0;
      reg_we  = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (psel && !penable) begin
               hit_d   = sel_hit;
               idx_d   = sel_idx;
               write_d = pwrite;
               wdata_d = pwdata;
               wcnt_d  = WaitInit;
               if (WaitInit == 4'd0) begin
                  state_d = StResp;
                  capture = 1'b1;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (!psel) begin
               state_d = StIdle;
            end else if (penable) begin
               wcnt_d = wcnt_q - 4'd1;
               if (wcnt_q == 4'd1) begin
                  state_d = StResp;
                  capture = 1'b1;
               end
            end
         end
         StResp: begin
            state_d = StIdle;
            // Commit only when the master completes the access phase; a dropped psel aborts.
            if (psel && penable && !err_q) begin
               cnt_inc = 1'b1;
               reg_we  = write_q;
            end
         end
         default: state_d = StIdle;
      endcase
      if (capture) begin
         err_d = !sel_hit || (sel_write && (sel_idx == CntIdx));
         if (!sel_hit) begin
            rdata_d = '0;
         end else if (sel_idx == CntIdx) begin
            rdata_d = cnt_q;
         end else begin
            rdata_d = regs_q[sel_idx];
         end
      end
   end

   assign cnt_d = cnt_inc ? cnt_q + 32'd1 : cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         wcnt_q  <= '0;
         hit_q   <= 1'b0;
         idx_q   <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         hit_q   <= hit_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Entry 6 is never written: err_q blocks writes to the counter slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= '0;
         end
      end else if (reg_we) begin
         regs_q[idx_q] <= wdata_q;
      end
   end

   assign pready  = (state_q == StResp);
   assign prdata  = rdata_q;
   assign pslverr = err_q;

endmodule
